btn_bounce_gen: RTL and testbench
=================================

# btn_bounce_gen

Synthesizable contact-bounce emulator: the transmit-side counterpart of the button debounce filter. It converts a clean level command into a raw, bouncy button waveform, so filters can be exercised on-board and in simulation without hand-written glitch sequences. It sits between a stimulus source (switch, host register, or testbench) and the raw-button input of a filter instance.

## Interface
- `BOUNCES`, default 3: number of bounce pairs per edge, range 1..15. One pair is a segment at the target level followed by a segment at the inverse level.
- `SEG_W`, default 2: segment-length field width, range 1..4. Segment length is 1..2^SEG_W cycles.
- `SEED`, default 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.
- `clock`, in, 1: single system clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `cleanIn`, in, 1: requested clean button level. Synchronous to `clock`.
- `rawButton`, out, 1: emulated bouncy button output, registered.
- `busy`, out, 1: high while a bounce sequence is in progress.
- `done`, out, 1: one-cycle strobe on the first settled cycle.

## Operation
- State register `level` holds the current target. FSM states are IDLE and BOUNCE.
- Reset values: `level`=0, `rawButton`=0, `busy`=0, `done`=0, FSM=IDLE, LFSR=SEED (0 is mapped to 1), segment and pair counters=0.
- In IDLE, if `cleanIn`==`level` on an edge, nothing changes.
- In IDLE, if `cleanIn`!=`level` on an edge:
  - `level` <= `cleanIn`.
  - FSM <= BOUNCE.
  - Segment index <= 0.
  - `rawButton` <= `cleanIn`.
  - Segment counter <= L-1.
- In BOUNCE, the sequence is 2*BOUNCES segments, indexed 0..2*BOUNCES-1.
  - Even-index segments drive `level`. Odd-index segments drive ~`level`.
  - Each segment lasts L cycles. The segment counter decrements every cycle.
  - When the counter is 0, the index advances, `rawButton` toggles, and the counter reloads with a fresh L-1.
- After the last segment (odd index, inverse level) expires:
  - FSM <= IDLE.
  - `rawButton` <= `level`.
  - `done` <= 1 for exactly one cycle.
- `busy` = (FSM==BOUNCE), registered together with the FSM.
- Changes on `cleanIn` during BOUNCE are ignored. On the first IDLE edge the compare runs again, so a reverted request starts a new sequence back to the old level immediately.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts left every cycle in all states. It never reaches 0.
- Widths: segment counter is SEG_W bits. Pair/segment index is 5 bits. No arithmetic overflow is possible within the legal parameter ranges.

## Timing
- Latency: a `cleanIn` change sampled at edge E0 appears on `rawButton` after edge E0, i.e. a 1-cycle registered delay.
- Sequence duration is the sum of L over all 2*BOUNCES segments. In fixed mode this is 2*BOUNCES*2^SEG_W cycles.
- `done` and `busy`:
  - `done` asserts in the same cycle that `rawButton` first holds the final level and `busy` falls.
  - `done` and `busy` are never high together.
- A mid-sequence reset takes effect at the next edge: all outputs return to reset values and any pending request is discarded.
- If `cleanIn`!=0 while `reset` is high, a sequence starts on the first edge after `reset` deasserts.

## Configuration
- Macro `BTN_BOUNCE_LFSR_EN`, defined: L = 1 + LFSR[SEG_W-1:0], sampled at each counter load. Segment lengths are pseudo-random and reproducible from SEED.
- Macro undefined: L = 2^SEG_W for every segment. The LFSR still runs but has no effect on `rawButton`.
- All other behaviour is identical in both builds.

## Test plan
- Fixed mode, defaults, reset then `cleanIn` 0->1 at edge 0:
  - `rawButton` is 1 in cycles 1-4, 0 in 5-8, 1 in 9-12, 0 in 13-16, 1 in 17-20, 0 in 21-24.
  - From cycle 25 `rawButton` stays 1, with `done`=1 only in cycle 25 and `busy`=1 for cycles 1-24.
- Fixed mode, after a settled 1, `cleanIn` 1->0: the mirrored pattern appears, ending at 0 in cycle 25 with a single `done` pulse.
- `cleanIn` 0->1->0 within BOUNCE: the first sequence completes to 1, then a second sequence starts on the first IDLE edge and settles to 0.
- Reset asserted in cycle 10 of a sequence: from cycle 11 all outputs are 0 and the FSM is IDLE. After release with `cleanIn`=1, a fresh sequence starts.
- LFSR mode, SEED=16'hACE1:
  - Every segment length lies in 1..4, with exactly 6 toggles and a final level equal to `cleanIn`.
  - Two runs from reset produce identical waveforms.
- SEED=0: the LFSR loads 16'h0001 and the generator still produces a sequence (no lock-up).

Source files
------------

// File: rtl/btn_bounce_gen.sv
// btn_bounce_gen: contact-bounce emulator. It turns a clean level command
// into a bouncy button waveform that can drive a debounce filter.
//
// Parameters:
//   BOUNCES - bounce pairs per edge (1..15)
//   SEG_W   - segment length field width (1..4); a segment is 1..2^SEG_W cycles
//   SEED    - LFSR reset value (0 is replaced by 16'h0001)
// Ports:
//   clock     - system clock, rising edge
//   reset     - synchronous, active-high
//   cleanIn   - requested clean button level
//   rawButton - registered bouncy button output
//   busy      - high while a bounce sequence is in progress
//   done      - one-cycle strobe on the first settled cycle
// Build option:
//   BTN_BOUNCE_LFSR_EN defined   : segment length L = 1 + LFSR[SEG_W-1:0]
//   BTN_BOUNCE_LFSR_EN undefined : segment length L = 2^SEG_W (fixed)
module btn_bounce_gen #(
    parameter int unsigned BOUNCES = 3,
    parameter int unsigned SEG_W   = 2,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic clock,
    input  logic reset,
    input  logic cleanIn,
    output logic rawButton,
    output logic busy,
    output logic done
);

    typedef enum logic {
        IDLE,
        BOUNCE
    } state_t;

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [4:0]  LAST_IDX = 5'(2 * BOUNCES - 1);

    state_t             state;
    state_t             stateNxt;
    logic               level;
    logic               levelNxt;
    logic               rawNxt;
    logic               doneNxt;
    logic [SEG_W-1:0]   segCnt;
    logic [SEG_W-1:0]   segCntNxt;
    logic [SEG_W-1:0]   segLoad;
    logic [4:0]         segIdx;
    logic [4:0]         segIdxNxt;
    logic [15:0]        lfsr;
    logic               lfsrFb;

    // Fibonacci taps 16,14,13,11; a nonzero state never reaches zero.
    assign lfsrFb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Counter reload value is L-1.
`ifdef BTN_BOUNCE_LFSR_EN
    assign segLoad = lfsr[SEG_W-1:0];
`else
    assign segLoad = '1;
`endif

    always_comb begin
        stateNxt  = state;
        levelNxt  = level;
        rawNxt    = rawButton;
        segCntNxt = segCnt;
        segIdxNxt = segIdx;
        doneNxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cleanIn != level) begin
                    levelNxt  = cleanIn;
                    stateNxt  = BOUNCE;
                    segIdxNxt = 5'd0;
                    rawNxt    = cleanIn;
                    segCntNxt = segLoad;
                end
            end
            BOUNCE: begin
                if (segCnt != '0) begin
                    segCntNxt = segCnt - 1'b1;
                end else if (segIdx == LAST_IDX) begin
                    // Last (inverse-level) segment expired: settle.
                    stateNxt = IDLE;
                    rawNxt   = level;
                    doneNxt  = 1'b1;
                end else begin
                    segIdxNxt = segIdx + 5'd1;
                    rawNxt    = ~rawButton;
                    segCntNxt = segLoad;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            level     <= 1'b0;
            rawButton <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            segCnt    <= '0;
            segIdx    <= 5'd0;
            lfsr      <= SEED_EFF;
        end else begin
            state     <= stateNxt;
            level     <= levelNxt;
            rawButton <= rawNxt;
            busy      <= (stateNxt == BOUNCE);
            done      <= doneNxt;
            segCnt    <= segCntNxt;
            segIdx    <= segIdxNxt;
            lfsr      <= {lfsr[14:0], lfsrFb};
        end
    end

endmodule

// File: tb/tb_btn_bounce_gen.sv
// tb_btn_bounce_gen: scoreboard bench for btn_bounce_gen.
// Stimulus pushes expected {rawButton,busy,done}; a monitor pops and compares.
module tb_btn_bounce_gen;

    logic clock;
    logic reset;
    logic cleanIn;
    logic rawButton;
    logic busy;
    logic done;

    int nCmp;
    int nBad;

    typedef struct {
        logic [2:0] v;
        string      tag;
    } exp_t;

    exp_t expQ[$];

    btn_bounce_gen #(
        .BOUNCES(3),
        .SEG_W  (2),
        .SEED   (16'hACE1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cleanIn  (cleanIn),
        .rawButton(rawButton),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Monitor: outputs are valid every cycle; compare #1 after the edge.
    always begin
        exp_t e;
        @(posedge clock);
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            nCmp++;
            if ({rawButton, busy, done} !== e.v) begin
                nBad++;
                $display("FAIL %s: got raw/busy/done=%b required %b",
                         e.tag, {rawButton, busy, done}, e.v);
            end
            nCmp++;
            if (busy && done) begin
                nBad++;
                $display("FAIL %s: busy and done both high, required exclusive",
                         e.tag);
            end
        end
    end

    // Drive inputs on the falling edge; expectation is for after the next rise.
    task automatic step(input logic c, input logic r, input logic eRaw,
                        input logic eBusy, input logic eDone, input string tag);
        exp_t e;
        @(negedge clock);
        cleanIn = c;
        reset   = r;
        e.v     = {eRaw, eBusy, eDone};
        e.tag   = tag;
        expQ.push_back(e);
    endtask

    // Fixed mode, BOUNCES=3, SEG_W=2: six 4-cycle segments, E0..E23 busy,
    // E24 settles with done. Input reverts to ~tgt from edge revertAt on.
    task automatic bounce(input logic tgt, input int revertAt, input string tag);
        logic c;
        logic r;
        for (int k = 0; k < 24; k++) begin
            c = (revertAt >= 0 && k >= revertAt) ? ~tgt : tgt;
            r = ((k / 4) % 2 == 0) ? tgt : ~tgt;
            step(c, 1'b0, r, 1'b1, 1'b0, $sformatf("%s_e%0d", tag, k));
        end
        c = (revertAt >= 0) ? ~tgt : tgt;
        step(c, 1'b0, tgt, 1'b0, 1'b1, $sformatf("%s_settle", tag));
    endtask

`ifdef BTN_BOUNCE_LFSR_EN
    task automatic lfsrRun(output logic [79:0] wav, output int endIdx);
        @(negedge clock);
        reset   = 1'b1;
        cleanIn = 1'b0;
        @(negedge clock);
        cleanIn = 1'b1;
        reset   = 1'b0;
        wav     = '0;
        endIdx  = -1;
        for (int i = 0; i < 80; i++) begin
            @(posedge clock);
            #1;
            wav[i] = rawButton;
            if (done && endIdx < 0) endIdx = i;
            if (endIdx >= 0) break;
        end
    endtask

    task automatic lfsrCheck();
        logic [79:0] w1;
        logic [79:0] w2;
        int e1;
        int e2;
        int tog;
        int run;
        int badSeg;
        lfsrRun(w1, e1);
        lfsrRun(w2, e2);
        nCmp++;
        if (e1 < 0) begin
            nBad++;
            $display("FAIL lfsr_timeout: got no done required done within 80");
        end else begin
            tog    = 0;
            run    = 1;
            badSeg = 0;
            for (int i = 1; i <= e1; i++) begin
                if (w1[i] != w1[i-1]) begin
                    tog++;
                    if (run < 1 || run > 4) badSeg++;
                    run = 1;
                end else begin
                    run++;
                end
            end
            nCmp++;
            if (tog != 6) begin
                nBad++;
                $display("FAIL lfsr_toggles: got %0d required 6", tog);
            end
            nCmp++;
            if (badSeg != 0) begin
                nBad++;
                $display("FAIL lfsr_seglen: got %0d bad segments required 0",
                         badSeg);
            end
            nCmp++;
            if (w1[e1] !== 1'b1) begin
                nBad++;
                $display("FAIL lfsr_final: got %b required 1", w1[e1]);
            end
        end
        nCmp++;
        if (e1 != e2 || w1 !== w2) begin
            nBad++;
            $display("FAIL lfsr_repeat: got len %0d/%0d required identical runs",
                     e1, e2);
        end
    endtask
`endif

    initial begin
        int waitCnt;
        nCmp    = 0;
        nBad    = 0;
        reset   = 1'b1;
        cleanIn = 1'b0;

        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "reset0");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "reset1");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle_same");

`ifdef BTN_BOUNCE_LFSR_EN
        while (expQ.size() > 0) @(negedge clock);
        lfsrCheck();
`else
        // Rising press, then the mirrored release.
        bounce(1'b1, -1, "rise");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "rise_hold");
        bounce(1'b0, -1, "fall");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "fall_hold");

        // Request reverted mid-sequence: completes to 1, then back to 0.
        bounce(1'b1, 2, "revert");
        bounce(1'b0, -1, "revert_back");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "revert_hold");

        // Reset sampled at E10 of a sequence, held with cleanIn=1.
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0, ((k / 4) % 2 == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0,
                 $sformatf("pre_rst_e%0d", k));
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "mid_rst0");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "mid_rst1");
        bounce(1'b1, -1, "post_rst");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "post_rst_hold");
`endif

        waitCnt = 0;
        while (expQ.size() > 0 && waitCnt < 10) begin
            @(negedge clock);
            waitCnt++;
        end
        nCmp++;
        if (expQ.size() != 0) begin
            nBad++;
            $display("FAIL drain: got %0d pending required 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
